// File: rtl/tone_gen_multi.sv
// tone_gen_multi: CH independent square-wave pitch clocks from one system clock.
// Each channel takes new settings through a valid/ready write port. Settings
// wait in a per-channel pending slot and are applied only at a period boundary,
// or at once when the channel is idle, so output pulses are never cut short.
// Optional build macro: TONE_DUTY_EN (programmable duty from wr_duty; otherwise
// the high threshold is fixed at div/2 and wr_duty is ignored).
`timescale 1ns/1ps
module tone_gen_multi #(
  parameter int CH = 4,
  parameter int DW = 21,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_ch,
  input  logic [DW-1:0] wr_div,
  input  logic [7:0]    wr_duty,
  input  logic          wr_en,
  output logic [CH-1:0] pitch_clk,
  output logic [CH-1:0] active,
  output logic [CW:0]   mix_level
);

  logic [DW-1:0] count    [CH];
  logic [DW-1:0] div_act  [CH];
  logic [DW-1:0] th_act   [CH];
  logic [DW-1:0] div_pend [CH];
  logic [DW-1:0] th_pend  [CH];
  logic [CH-1:0] en_act;
  logic [CH-1:0] en_pend;
  logic [CH-1:0] pend;
  logic [CH-1:0] dz_act;
  logic [CH-1:0] dz_pend;
  logic [CH-1:0] apply;
  logic          stall;
  logic          ch_ok;
  logic          accept;
  logic [DW-1:0] th_new;
  logic          dz_new;
  logic [CW:0]   pop;

`ifdef TONE_DUTY_EN
  // High threshold from duty: th = div*(256-duty)/256, wide enough not to overflow.
  logic [DW+7:0] duty_prod;
  assign duty_prod = (DW+8)'(wr_div) * (DW+8)'(9'd256 - {1'b0, wr_duty});
  assign th_new    = DW'(duty_prod >> 8);
  // duty=0 would otherwise leave a one-cycle pulse in the reload cycle.
  assign dz_new    = (wr_duty == 8'd0);
`else
  logic unused_duty;
  assign unused_duty = ^wr_duty;
  assign th_new      = wr_div >> 1;
  assign dz_new      = 1'b0;
`endif

  assign active   = en_act;
  // Out-of-range channel indices are always accepted and silently dropped.
  assign ch_ok    = ({1'b0, wr_ch} < (CW+1)'(CH));
  assign wr_ready = !stall && (!ch_ok || !pend[wr_ch]);
  assign accept   = wr_valid && wr_ready && ch_ok;

  // Pending settings are consumed at the period boundary or when the channel is idle.
  always_comb begin
    apply = '0;
    for (int i = 0; i < CH; i++) begin
      apply[i] = pend[i] && ((count[i] == '0) || !en_act[i]);
    end
  end

  // Number of channels currently high, feeding the registered mix level.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CH; i++) begin
      pop = pop + (CW+1)'(pitch_clk[i]);
    end
  end

  // Per-channel counters, pending/applied settings, outputs and mix register.
  always_ff @(posedge clk) begin
    if (reset_) begin
      stall     <= 1'b1;
      pitch_clk <= '0;
      en_act    <= '0;
      en_pend   <= '0;
      pend      <= '0;
      dz_act    <= '0;
      dz_pend   <= '0;
      mix_level <= '0;
      for (int i = 0; i < CH; i++) begin
        count[i]    <= '0;
        div_act[i]  <= '0;
        th_act[i]   <= '0;
        div_pend[i] <= '0;
        th_pend[i]  <= '0;
      end
    end else begin
      stall     <= 1'b0;
      mix_level <= pop;
      for (int i = 0; i < CH; i++) begin
        pitch_clk[i] <= en_act[i] && (div_act[i] != '0) &&
                        (count[i] >= th_act[i]) && !dz_act[i];
        if (apply[i]) begin
          div_act[i] <= div_pend[i];
          th_act[i]  <= th_pend[i];
          en_act[i]  <= en_pend[i];
          dz_act[i]  <= dz_pend[i];
          pend[i]    <= 1'b0;
          count[i]   <= en_pend[i] ? div_pend[i] : '0;
        end else if (!en_act[i] || (div_act[i] == '0)) begin
          count[i] <= '0;
        end else if (count[i] == '0) begin
          count[i] <= div_act[i];
        end else begin
          count[i] <= count[i] - DW'(1);
        end
        // pend blocks wr_ready, so accept and apply never hit the same channel.
        if (accept && (wr_ch == CW'(i))) begin
          pend[i]     <= 1'b1;
          div_pend[i] <= wr_div;
          th_pend[i]  <= th_new;
          en_pend[i]  <= wr_en;
          dz_pend[i]  <= dz_new;
        end
      end
    end
  end

endmodule

// File: doc/tone_gen_multi.md
Name: tone_gen_multi

Overview:
Parametrised multi-channel successor to the single-channel pitch divider. Generates CH independent square-wave pitch clocks from one system clock. Each channel is programmed through a valid/ready write port. New settings are applied only at a period boundary, so tone changes and stops never produce runt pulses. A registered mix level (count of channels currently high) feeds the downstream audio summer/PWM stage.

Parameters:
CH, 4, number of tone channels (1..16)
DW, 21, divider/counter width in bits
CW, $clog2(CH) (min 1), channel-index width (derived; not for override)

Ports:
clk  input  1  system clock
reset_  input  1  synchronous, active-high reset (name kept per codebase; high = reset)
wr_valid  input  1  write request
wr_ready  output  1  write can be accepted this cycle
wr_ch  input  CW  target channel index
wr_div  input  DW  divider value; period = wr_div+1 clk cycles
wr_duty  input  8  high-time fraction, duty/256 (used only with TONE_DUTY_EN)
wr_en  input  1  channel enable to apply
pitch_clk  output  CH  per-channel tone outputs, registered
active  output  CH  per-channel applied enable (en_act)
mix_level  output  CW+1  registered popcount of pitch_clk

Behaviour:
- Reset: this behaviour applies on any clk edge with reset_=1, including mid-operation. Clears all of the following to 0: pitch_clk, active, mix_level, wr_ready, every count, div_act, th_act, div_pend, th_pend, en_pend, pend.
- Stall: wr_ready stays 0 for the first cycle after reset_ falls.
- wr_ready (combinational) = !stall && !pend[wr_ch]; for wr_ch >= CH, wr_ready=1 and the write is dropped.
- Accept: a write is accepted when wr_valid && wr_ready.
  - On accept, latch div_pend=wr_div, en_pend=wr_en, th_pend (see threshold rule), and set pend[wr_ch].
  - A second write to a channel with pend set is back-pressured, never overwritten.
- Per-channel apply: pend is consumed when the channel's count==0 or en_act==0. On that edge:
  - div_act<=div_pend, th_act<=th_pend, en_act<=en_pend, pend<=0.
  - count<=div_pend if en_pend, else count<=0.
- Counter, when not applying:
  - en_act=0 or div_act=0: count held at 0.
  - count==0: count<=div_act.
  - otherwise: count<=count-1.
- Output: pitch_clk[i]<=en_act && div_act!=0 && count>=th_act, evaluated on pre-edge values (one-cycle registered).
- Disable (wr_en=0) takes effect at the end of the current period; pitch_clk is then 0 from the next edge.
- div=0 on an enabled channel: output held 0 and active=1; a subsequent write applies on the next edge, since count==0.
- mix_level <= popcount(pitch_clk), one cycle behind pitch_clk.
- Simultaneous accept and apply on the same channel: impossible, because pend blocks ready. Accept on channel A while channel B applies: both proceed independently.
- All arithmetic is unsigned DW-bit; the counter never wraps below 0.

Optional Feature:
TONE_DUTY_EN
- Defined: th_pend=(wr_div*(256-wr_duty))>>8, computed at accept with a DW+8-bit intermediate.
  - wr_duty=128 gives roughly 50% duty.
  - wr_duty=0 forces the output to 0, since th=div while the count only reaches div in the reload cycle. In that reload-cycle case, treat the output as high only if duty!=0.
- Undefined: th_pend=wr_div>>1 (fixed 50%). wr_duty is ignored and carries no logic.

Test Plan:
- Reset then write ch0 div=9, en=1 -> wr_ready 0 for one cycle post-reset. pitch_clk[0] then has period 10 clk, high for count 9..4 (6 cycles), low 4 cycles. active[0]=1.
- ch0 running div=9; write div=19 mid-period -> the current 10-cycle period completes unchanged, the next period is 20 cycles, and no pulse is shorter than 4 cycles.
- Two back-to-back writes to ch1 before its boundary -> the second sees wr_ready=0 until pend clears. The second value applies one period later.
- ch0 div=3 and ch1 div=7, both enabled -> mix_level equals the popcount of pitch_clk delayed one cycle, reaching 2 when both are high. wr_ch=7 (CH=4) is ignored.
- Disable ch0 mid-high-phase -> high phase and period finish, then pitch_clk[0]=0 and active[0]=0. Assert reset_ for one cycle mid-tone -> all outputs 0 on the next edge.
- TONE_DUTY_EN: div=99, duty=64 -> high 26 of 100 cycles. duty=0 -> output constantly 0.
